// File: rtl/vga_timing_pkg.sv
// vga_timing: shared 640x480@60 timing constants for the sync generator,
// pixel pipelines and game logic. Totals are derived from the segments.
package vga_timing;

   localparam int unsigned CNT_W   = 10;

   localparam int unsigned H_DISP  = 640;
   localparam int unsigned H_FP    = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_BP    = 48;
   localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_DISP  = 480;
   localparam int unsigned V_FP    = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_BP    = 33;
   localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: clock-enable divider. A count runs 0..DIV-1 every clk;
// p_tick is high in exactly the clk where the count equals DIV-1.
// Ports: clk (system clock), reset (sync, active-low), p_tick (enable pulse).
module pixel_tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;

   // next divider count with wrap at DIV-1
   always_comb begin
      cnt_n = cnt + CW'(1);
      if (cnt == CW'(DIV - 1)) begin
         cnt_n = '0;
      end
   end

   // p_tick registered from the next count so it tracks cnt == DIV-1
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         p_tick <= 1'b0;
      end else begin
         cnt    <= cnt_n;
         p_tick <= (cnt_n == CW'(DIV - 1));
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters and sync generation driven by a pixel
// clock enable (no derived clocks).
// Ports: clk, reset (sync, active-low); hsync/vsync (active-low, registered);
// video_on (visible area, registered); pixel_x/pixel_y (current position);
// p_tick (pixel advance enable); f_tick (one-clk strobe on wrap to (0,0)).
// Porch/sync widths default to the shared vga_timing constants.
module vga_sync_gen #(
   parameter int unsigned DIV    = 4,
   parameter int unsigned H_DISP = vga_timing::H_DISP,
   parameter int unsigned V_DISP = vga_timing::V_DISP,
   parameter int unsigned H_FP   = vga_timing::H_FP,
   parameter int unsigned H_SYNC = vga_timing::H_SYNC,
   parameter int unsigned H_BP   = vga_timing::H_BP,
   parameter int unsigned V_FP   = vga_timing::V_FP,
   parameter int unsigned V_SYNC = vga_timing::V_SYNC,
   parameter int unsigned V_BP   = vga_timing::V_BP
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       p_tick,
   output logic       f_tick
);

   localparam int unsigned CW       = vga_timing::CNT_W;
   localparam int unsigned H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_DISP + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_DISP + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [CW-1:0] x_n;
   logic [CW-1:0] y_n;
   logic          wrap;

   pixel_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   // next raster position; advances only on a pixel tick
   always_comb begin
      x_n  = pixel_x;
      y_n  = pixel_y;
      wrap = 1'b0;
      if (p_tick) begin
         if (pixel_x == CW'(H_TOT - 1)) begin
            x_n = '0;
            if (pixel_y == CW'(V_TOT - 1)) begin
               y_n  = '0;
               wrap = 1'b1;
            end else begin
               y_n = pixel_y + CW'(1);
            end
         end else begin
            x_n = pixel_x + CW'(1);
         end
      end
   end

   // counters plus sync/video flags decoded from the next position, updated
   // only on tick edges so video_on stays low at (0,0) until the first advance
   always_ff @(posedge clk) begin
      if (!reset) begin
         pixel_x  <= '0;
         pixel_y  <= '0;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b0;
         f_tick   <= 1'b0;
      end else begin
         pixel_x <= x_n;
         pixel_y <= y_n;
         f_tick  <= wrap;
         if (p_tick) begin
            hsync    <= !((x_n >= CW'(HS_START)) && (x_n < CW'(HS_END)));
            vsync    <= !((y_n >= CW'(VS_START)) && (y_n < CW'(VS_END)));
            video_on <= (x_n < CW'(H_DISP)) && (y_n < CW'(V_DISP));
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen. A default 640x480 DIV=4
// instance covers reset, tick cadence and line timing; a miniature instance
// (DIV=2, 16x13 raster: H 8/2/3/3, V 6/2/2/3) covers frame-level behaviour
// within a short run.
module tb_vga_sync_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b0;

   logic       d_hs, d_vs, d_vid, d_pt, d_ft;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_vid, s_pt, s_ft;
   logic [9:0] s_x, s_y;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_sync_gen u_dut (
      .clk      (clk),
      .reset    (reset),
      .hsync    (d_hs),
      .vsync    (d_vs),
      .video_on (d_vid),
      .pixel_x  (d_x),
      .pixel_y  (d_y),
      .p_tick   (d_pt),
      .f_tick   (d_ft)
   );

   vga_sync_gen #(
      .DIV(2), .H_DISP(8), .V_DISP(6),
      .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_small (
      .clk      (clk),
      .reset    (reset),
      .hsync    (s_hs),
      .vsync    (s_vs),
      .video_on (s_vid),
      .pixel_x  (s_x),
      .pixel_y  (s_y),
      .p_tick   (s_pt),
      .f_tick   (s_ft)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      checks++;
      if ({d_x, d_y} !== 20'd0) begin
         failures++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", d_x, d_y);
      end
      checks++;
      if ({d_hs, d_vs, d_vid, d_pt, d_ft} !== 5'b11000) begin
         failures++; $display("FAIL reset_flags: got hs/vs/vid/pt/ft=%b want 11000",
                              {d_hs, d_vs, d_vid, d_pt, d_ft});
      end
      checks++;
      if ({s_x, s_y, s_hs, s_vs, s_vid, s_pt, s_ft} !== {20'd0, 5'b11000}) begin
         failures++; $display("FAIL reset_small: got x=%0d y=%0d flags=%b want 0 0 11000",
                              s_x, s_y, {s_hs, s_vs, s_vid, s_pt, s_ft});
      end
   endtask

   // after the last reset edge: p_tick in the 3rd sample, (1,0) in the 4th
   task automatic test_release(input string tag);
      reset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (d_pt !== (k == 3)) begin
            failures++; $display("FAIL %s_ptick_k%0d: got %b want %b", tag, k, d_pt, (k == 3));
         end
         if (k < 4) begin
            checks++;
            if ({d_x, d_y, d_vid} !== 21'd0) begin
               failures++; $display("FAIL %s_hold_k%0d: got x=%0d y=%0d vid=%b want 0 0 0",
                                    tag, k, d_x, d_y, d_vid);
            end
         end
      end
      checks++;
      if ({d_x, d_y, d_vid} !== {10'd1, 10'd0, 1'b1}) begin
         failures++; $display("FAIL %s_first_adv: got x=%0d y=%0d vid=%b want 1 0 1",
                              tag, d_x, d_y, d_vid);
      end
   endtask

   task automatic test_free_run();
      int  bad = 0;
      bit  found = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (d_pt !== ((k % 4) == 3)) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL ptick_cadence: got %0d wrong cycles want 0", bad);
      end
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         if (d_x == 10'd639) found = 1;
      end
      checks++;
      if (!found || d_vid !== 1'b1) begin
         failures++; $display("FAIL x639_visible: got found=%b vid=%b want 1 1", found, d_vid);
      end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         if (d_x != 10'd639) found = 1;
      end
      checks++;
      if (!found || d_x !== 10'd640 || d_vid !== 1'b0) begin
         failures++; $display("FAIL x640_blank: got x=%0d vid=%b want 640 0", d_x, d_vid);
      end
   endtask

   task automatic test_line_scan();
      int lo = 0;
      int first = -1;
      int last = -1;
      bit done = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         step();
         if (d_hs === 1'b0) begin
            if (lo == 0) first = int'(d_x);
            last = int'(d_x);
            lo++;
         end
         if (d_x == 10'd0) done = 1;
      end
      checks++;
      if (!done || d_y !== 10'd1) begin
         failures++; $display("FAIL line_wrap: got done=%b y=%0d want 1 1", done, d_y);
      end
      checks++;
      if (lo != 384) begin
         failures++; $display("FAIL hsync_width: got %0d clks want 384", lo);
      end
      checks++;
      if (first != 656 || last != 751) begin
         failures++; $display("FAIL hsync_span: got %0d..%0d want 656..751", first, last);
      end
   endtask

   task automatic test_frame();
      bit found = 0;
      int n = 0;
      int ft_cnt = 0, vs_lo = 0, hs_lo = 0, vid_hi = 0;
      int vs_min = 1023, vs_max = -1;
      for (int i = 0; i < 1000 && !found; i++) begin
         step();
         if (s_x == 10'd15 && s_y == 10'd12) found = 1;
      end
      found = 0;
      for (int i = 0; i < 4 && !found && n == 0; i++) begin
         step();
         if (s_x != 10'd15) found = 1;
      end
      checks++;
      if (!found || {s_x, s_y, s_ft, s_vid} !== {20'd0, 2'b11}) begin
         failures++; $display("FAIL frame_wrap: got x=%0d y=%0d ft=%b vid=%b want 0 0 1 1",
                              s_x, s_y, s_ft, s_vid);
      end
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (s_ft) ft_cnt++;
         if (!s_hs) hs_lo++;
         if (s_vid) vid_hi++;
         if (!s_vs) begin
            vs_lo++;
            if (int'(s_y) < vs_min) vs_min = int'(s_y);
            if (int'(s_y) > vs_max) vs_max = int'(s_y);
         end
         step();
         n++;
         if (s_ft) found = 1;
      end
      checks++;
      if (!found || n != 416) begin
         failures++; $display("FAIL frame_period: got %0d clks want 416", n);
      end
      checks++;
      if (ft_cnt != 1) begin
         failures++; $display("FAIL ftick_width: got %0d clks want 1", ft_cnt);
      end
      checks++;
      if (vs_lo != 64 || vs_min != 8 || vs_max != 9) begin
         failures++; $display("FAIL vsync_span: got %0d clks y %0d..%0d want 64 clks y 8..9",
                              vs_lo, vs_min, vs_max);
      end
      checks++;
      if (hs_lo != 78) begin
         failures++; $display("FAIL hsync_frame: got %0d clks want 78", hs_lo);
      end
      checks++;
      if (vid_hi != 96) begin
         failures++; $display("FAIL video_area: got %0d clks want 96", vid_hi);
      end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step();
         if (s_x == 10'd5 && s_y == 10'd4) found = 1;
      end
      checks++;
      if (!found || s_vid !== 1'b1) begin
         failures++; $display("FAIL mid_reach: got found=%b vid=%b want 1 1", found, s_vid);
      end
      reset = 1'b0;
      step();
      checks++;
      if ({s_x, s_y, s_hs, s_vs, s_vid, s_pt, s_ft} !== {20'd0, 5'b11000}) begin
         failures++; $display("FAIL mid_abort: got x=%0d y=%0d flags=%b want 0 0 11000",
                              s_x, s_y, {s_hs, s_vs, s_vid, s_pt, s_ft});
      end
      reset = 1'b1;
      step();
      checks++;
      if (s_pt !== 1'b1 || s_x !== 10'd0) begin
         failures++; $display("FAIL mid_small_tick: got pt=%b x=%0d want 1 0", s_pt, s_x);
      end
      step();
      checks++;
      if ({s_x, s_y} !== {10'd1, 10'd0}) begin
         failures++; $display("FAIL mid_small_adv: got x=%0d y=%0d want 1 0", s_x, s_y);
      end
      reset = 1'b0;
      step();
      test_release("mid");
   endtask

   initial begin
      test_reset();
      test_release("rel");
      test_free_run();
      test_line_scan();
      test_frame();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter DIV, default 4: system clocks per pixel (100 MHz clk to 25 MHz pixel rate).
REQ-002 Parameter H_DISP, default 640: visible pixels per line.
REQ-003 Parameter V_DISP, default 480: visible lines per frame.
REQ-004 clk  input  1: single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 hsync  output  1: horizontal sync, registered, active-low.
REQ-007 vsync  output  1: vertical sync, registered, active-low.
REQ-008 video_on  output  1: registered; high when the current pixel is in the visible area.
REQ-009 pixel_x  output  10: current column, 0..799.
REQ-010 pixel_y  output  10: current line, 0..524.
REQ-011 p_tick  output  1: one-clk pulse marking each pixel advance.
REQ-012 f_tick  output  1: one-clk pulse when the counters wrap to (0,0); used as the game-object update strobe.

Function
REQ-013 A divider count (0..DIV-1) SHALL increment every clk and wrap; p_tick SHALL be high in exactly the clk where the count equals DIV-1.
REQ-014 pixel_x and pixel_y SHALL change only on the clk edge that ends a p_tick cycle; otherwise they hold.
REQ-015 Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799 (800 total).
REQ-016 Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524 (525 total).
REQ-017 pixel_x SHALL wrap from 799 to 0; on that wrap, pixel_y SHALL increment, or wrap from 524 to 0.
REQ-018 hsync, vsync and video_on SHALL be registered from the next-state counter values so that they always match the pixel_x/pixel_y presented in the same cycle.
REQ-019 hsync SHALL be 0 iff pixel_x is in 656..751; vsync SHALL be 0 iff pixel_y is in 490..491.
REQ-020 video_on SHALL be 1 iff pixel_x < H_DISP and pixel_y < V_DISP.
REQ-021 f_tick SHALL be high for exactly one clk, on the edge at which the counters move from (799,524) to (0,0).
REQ-022 Boundary: at the first (0,0) after reset, video_on SHALL read 0 until the first counter advance. Every later frame SHALL be fully consistent.
REQ-023 Frame period SHALL be exactly 800*525*DIV clks (1,680,000 at DIV=4); there is no stall or enable input.

Reset
REQ-024 While reset=0 at a clk edge: divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, p_tick=0, f_tick=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame on that edge. Counting SHALL restart from (0,0) on the first edge with reset=1, with the first p_tick DIV clks later.

Structure
REQ-026 Timing constants SHALL live in a shared package/include (vga_timing) for reuse by pixel and game logic: H_DISP, H_FP, H_SYNC, H_BP, H_TOTAL, V_DISP, V_FP, V_SYNC, V_BP, V_TOTAL.
REQ-027 The clock-enable divider SHALL be a sub-module, pixel_tick_gen (ports clk, reset, p_tick; parameter DIV).
REQ-028 No derived clocks SHALL be created; p_tick SHALL be used only as an enable.

Verification
REQ-029 Hold reset=0 for 3 clks at any point -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, p_tick=0, f_tick=0.
REQ-030 Free run after reset -> p_tick high on every 4th clk; pixel_x goes 639->640 with video_on going 1->0 on the same edge.
REQ-031 Line scan -> hsync low for exactly 96 pixel ticks (384 clks), from pixel_x=656 through 751; pixel_x 799->0 increments pixel_y.
REQ-032 Frame end at (799,524) -> next advance gives (0,0), f_tick high for 1 clk, and video_on=1.
REQ-033 Frame scan -> vsync low only for pixel_y 490..491 (1600 pixel ticks); f_tick interval = 1,680,000 clks.
REQ-034 Reset pulsed at (300,200) -> reset values on the next edge; the first p_tick comes 4 clks after release, then (1,0).
